// File: rtl/usbpd_bmc_tx_if.sv
// Byte-stream request interface for the USB-PD BMC transmitter.
//   tx_go/tx_sop      : start request and ordered-set select (client -> transmitter)
//   tx_dat/tx_vld/tx_last : payload byte stream (client -> transmitter)
//   tx_rdy            : byte consumed this cycle (transmitter -> client)
//   tx_busy/tx_done/tx_err : packet status (transmitter -> client)
interface usbpd_bmc_tx_if;
  logic       tx_go;
  logic [2:0] tx_sop;
  logic [7:0] tx_dat;
  logic       tx_vld;
  logic       tx_last;
  logic       tx_rdy;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_go, tx_sop, tx_dat, tx_vld, tx_last,
    input  tx_rdy, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_go, tx_sop, tx_dat, tx_vld, tx_last,
    output tx_rdy, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/usbpd_bmc_tx.sv
// USB-PD transmit framer and BMC line encoder.
// Sends preamble, ordered set, 4b5b payload, CRC-32 and EOP for one packet per request;
// Hard/Cable Reset requests send preamble and ordered set only.
// Ports:
//   clk, rstz : clock, asynchronous active-low reset
//   tx        : request/byte-stream interface (slave side)
//   cc_tx     : BMC line level
//   cc_oe     : CC driver enable
module usbpd_bmc_tx #(
  parameter int unsigned HALF_UI   = 20,
  parameter int unsigned PRE_BITS  = 64,
  parameter int unsigned MAX_BYTES = 30
) (
  input  logic          clk,
  input  logic          rstz,
  usbpd_bmc_tx_if.slave tx,
  output logic          cc_tx,
  output logic          cc_oe
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StOs   = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StCrc  = 3'd4;
  localparam logic [2:0] StEop  = 3'd5;
  localparam logic [2:0] StTail = 3'd6;

  localparam logic [15:0] HalfLast = 16'(HALF_UI - 1);
  localparam logic [15:0] PreLast  = 16'(PRE_BITS - 1);
  localparam logic [7:0]  MaxBytes = 8'(MAX_BYTES);

  localparam logic [4:0] KS1 = 5'b11000;
  localparam logic [4:0] KS2 = 5'b10001;
  localparam logic [4:0] KS3 = 5'b00110;
  localparam logic [4:0] KR1 = 5'b00111;
  localparam logic [4:0] KR2 = 5'b11001;
  localparam logic [4:0] KEop = 5'b01101;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    logic [4:0] s;
    case (n)
      4'h0: s = 5'b11110;  4'h1: s = 5'b01001;  4'h2: s = 5'b10100;  4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;  4'h5: s = 5'b01011;  4'h6: s = 5'b01110;  4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;  4'h9: s = 5'b10011;  4'hA: s = 5'b10110;  4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;  4'hD: s = 5'b11011;  4'hE: s = 5'b11100;  default: s = 5'b11101;
    endcase
    return s;
  endfunction

  // K-code number idx (0 = first sent) of the ordered set for this request.
  function automatic logic [4:0] os_sym(input logic [2:0] sop, input logic [1:0] idx);
    logic [19:0] s;
    case (sop)
      3'd0:    s = {KS2, KS1, KS1, KS1};
      3'd1:    s = {KS3, KS3, KS1, KS1};
      3'd2:    s = {KS3, KS1, KS3, KS1};
      3'd5:    s = {KR2, KR1, KR1, KR1};
      default: s = {KS3, KR1, KS1, KR1};
    endcase
    case (idx)
      2'd0:    return s[4:0];
      2'd1:    return s[9:5];
      2'd2:    return s[14:10];
      default: return s[19:15];
    endcase
  endfunction

  // Reflected CRC-32, one byte LSB first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic sop_legal(input logic [2:0] sop);
    return (sop == 3'd0) || (sop == 3'd1) || (sop == 3'd2) || (sop == 3'd5) || (sop == 3'd6);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic        half_q, half_d;     // 0: first half of the bit, 1: second half
  logic        cc_tx_q, cc_tx_d;
  logic        cc_oe_q, cc_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        cur_bit_q, cur_bit_d;
  logic [4:0]  sym_q, sym_d;
  logic [2:0]  bidx_q, bidx_d;     // bit position within sym_q
  logic [15:0] pcnt_q, pcnt_d;
  logic [2:0]  sidx_q, sidx_d;     // K-code / nibble index within the current field
  logic [2:0]  sop_q, sop_d;
  logic [7:0]  dat_q, dat_d;
  logic        last_q, last_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [31:0] crc_q, crc_d;

  logic        tick, rdy_c, ld, fetch, to_tail;
  logic [4:0]  ld_sym;
  logic [2:0]  nidx;
  logic [31:0] crc_inv;

  always_comb begin
    state_d   = state_q;   hcnt_d  = hcnt_q;   half_d  = half_q;
    cc_tx_d   = cc_tx_q;   cc_oe_d = cc_oe_q;  busy_d  = busy_q;
    abort_d   = abort_q;   cur_bit_d = cur_bit_q;
    sym_d     = sym_q;     bidx_d  = bidx_q;   pcnt_d  = pcnt_q;
    sidx_d    = sidx_q;    sop_d   = sop_q;    dat_d   = dat_q;
    last_d    = last_q;    bcnt_d  = bcnt_q;   crc_d   = crc_q;
    done_d    = 1'b0;      err_d   = 1'b0;     rdy_c   = 1'b0;
    ld        = 1'b0;      ld_sym  = 5'd0;     fetch   = 1'b0;   to_tail = 1'b0;
    crc_inv   = ~crc_q;
    nidx      = sidx_q + 3'd1;
    tick      = (hcnt_q == HalfLast);

    if (!busy_q) begin
      if (tx.tx_go && sop_legal(tx.tx_sop)) begin
        state_d   = StPre;   busy_d  = 1'b1;   cc_oe_d = 1'b1;
        cc_tx_d   = 1'b1;    // first bit start
        hcnt_d    = '0;      half_d  = 1'b0;   pcnt_d  = '0;
        cur_bit_d = 1'b0;    bidx_d  = '0;     sidx_d  = '0;
        sop_d     = tx.tx_sop;
        bcnt_d    = '0;      last_d  = 1'b0;   abort_d = 1'b0;
        crc_d     = 32'hFFFFFFFF;
      end
    end else begin
      hcnt_d = tick ? 16'd0 : hcnt_q + 16'd1;
      if (tick) half_d = ~half_q;

      if (state_q == StTail) begin
        if (tick) begin
          state_d = StIdle;  busy_d = 1'b0;  cc_oe_d = 1'b0;
          half_d  = 1'b0;    done_d = ~abort_q;
        end
      end else if (tick && !half_q) begin
        if (cur_bit_q) cc_tx_d = ~cc_tx_q;
      end else if (tick) begin
        // End of the current bit: pick the next one.
        if (state_q == StPre) begin
          if (pcnt_q == PreLast) begin
            state_d = StOs;  sidx_d = '0;
            ld = 1'b1;       ld_sym = os_sym(sop_q, 2'd0);
          end else begin
            pcnt_d    = pcnt_q + 16'd1;
            cur_bit_d = ~cur_bit_q;
          end
        end else if (bidx_q != 3'd4) begin
          bidx_d    = bidx_q + 3'd1;
          cur_bit_d = sym_q[bidx_q + 3'd1];
        end else begin
          case (state_q)
            StOs: begin
              if (sidx_q != 3'd3) begin
                sidx_d = nidx;
                ld = 1'b1;  ld_sym = os_sym(sop_q, nidx[1:0]);
              end else if (sop_q == 3'd5 || sop_q == 3'd6) begin
                to_tail = 1'b1;
              end else begin
                fetch = 1'b1;
              end
            end
            StData: begin
              if (sidx_q == 3'd0) begin
                sidx_d = 3'd1;
                ld = 1'b1;  ld_sym = enc4b5b(dat_q[7:4]);
              end else if (last_q) begin
                state_d = StCrc;  sidx_d = '0;
                ld = 1'b1;  ld_sym = enc4b5b(crc_inv[3:0]);
              end else begin
                fetch = 1'b1;
              end
            end
            StCrc: begin
              if (sidx_q == 3'd7) begin
                state_d = StEop;
                ld = 1'b1;  ld_sym = KEop;
              end else begin
                sidx_d = nidx;
                ld = 1'b1;  ld_sym = enc4b5b(crc_inv[{nidx, 2'b00} +: 4]);
              end
            end
            default: to_tail = 1'b1;
          endcase
        end

        if (fetch) begin
          if (!tx.tx_vld || bcnt_q == MaxBytes) begin
            err_d = 1'b1;  abort_d = 1'b1;  to_tail = 1'b1;
          end else begin
            rdy_c   = 1'b1;
            dat_d   = tx.tx_dat;
            last_d  = tx.tx_last;
            bcnt_d  = bcnt_q + 8'd1;
            crc_d   = crc_upd(crc_q, tx.tx_dat);
            state_d = StData;  sidx_d = '0;
            ld = 1'b1;  ld_sym = enc4b5b(tx.tx_dat[3:0]);
          end
        end

        if (ld) begin
          sym_d     = ld_sym;
          bidx_d    = '0;
          cur_bit_d = ld_sym[0];
        end

        // Entering TAIL forces the line low: a transition only if it was high.
        if (to_tail) begin
          state_d = StTail;
          cc_tx_d = 1'b0;
        end else begin
          cc_tx_d = ~cc_tx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= StIdle;  hcnt_q  <= '0;    half_q  <= 1'b0;
      cc_tx_q   <= 1'b0;    cc_oe_q <= 1'b0;  busy_q  <= 1'b0;
      done_q    <= 1'b0;    err_q   <= 1'b0;  abort_q <= 1'b0;
      cur_bit_q <= 1'b0;    sym_q   <= '0;    bidx_q  <= '0;
      pcnt_q    <= '0;      sidx_q  <= '0;    sop_q   <= '0;
      dat_q     <= '0;      last_q  <= 1'b0;  bcnt_q  <= '0;
      crc_q     <= 32'hFFFFFFFF;
    end else begin
      state_q   <= state_d;   hcnt_q  <= hcnt_d;   half_q  <= half_d;
      cc_tx_q   <= cc_tx_d;   cc_oe_q <= cc_oe_d;  busy_q  <= busy_d;
      done_q    <= done_d;    err_q   <= err_d;    abort_q <= abort_d;
      cur_bit_q <= cur_bit_d; sym_q   <= sym_d;    bidx_q  <= bidx_d;
      pcnt_q    <= pcnt_d;    sidx_q  <= sidx_d;   sop_q   <= sop_d;
      dat_q     <= dat_d;     last_q  <= last_d;   bcnt_q  <= bcnt_d;
      crc_q     <= crc_d;
    end
  end

  assign tx.tx_rdy  = rdy_c;
  assign tx.tx_busy = busy_q;
  assign tx.tx_done = done_q;
  assign tx.tx_err  = err_q;
  assign cc_tx      = cc_tx_q;
  assign cc_oe      = cc_oe_q;

endmodule

// File: tb/tb_usbpd_bmc_tx.sv
`timescale 1ns/1ps
module tb_usbpd_bmc_tx;
  localparam int H    = 4;
  localparam int PRE  = 64;
  localparam int MAXB = 30;

  logic clk  = 1'b0;
  logic rstz = 1'b0;
  logic cc_tx, cc_oe;

  usbpd_bmc_tx_if bus ();

  usbpd_bmc_tx #(.HALF_UI(H), .PRE_BITS(PRE), .MAX_BYTES(MAXB)) dut (
    .clk   (clk),
    .rstz  (rstz),
    .tx    (bus),
    .cc_tx (cc_tx),
    .cc_oe (cc_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   sop;
    int           nbytes;
    int           drop_at;
    bit           send_last;
    bit           go_again;
    logic [247:0] data;
    int           exp_bits;
    int           exp_rdy;
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  vec_t vecs [8];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic samp [$];
  logic exp_q [$];
  logic dec_q [$];
  int   rdy_n, done_n, err_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [4:0] enc5(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;  4'h1: return 5'b01001;  4'h2: return 5'b10100;
      4'h3: return 5'b10101;  4'h4: return 5'b01010;  4'h5: return 5'b01011;
      4'h6: return 5'b01110;  4'h7: return 5'b01111;  4'h8: return 5'b10010;
      4'h9: return 5'b10011;  4'hA: return 5'b10110;  4'hB: return 5'b10111;
      4'hC: return 5'b11010;  4'hD: return 5'b11011;  4'hE: return 5'b11100;
      default: return 5'b11101;
    endcase
  endfunction

  // Ordered set as four K-codes, first-sent in the low field.
  function automatic logic [19:0] os_of(input logic [2:0] sop);
    case (sop)
      3'd0:    return {5'b10001, 5'b11000, 5'b11000, 5'b11000};
      3'd1:    return {5'b00110, 5'b00110, 5'b11000, 5'b11000};
      3'd2:    return {5'b00110, 5'b11000, 5'b00110, 5'b11000};
      3'd5:    return {5'b11001, 5'b00111, 5'b00111, 5'b00111};
      default: return {5'b00110, 5'b00111, 5'b11000, 5'b00111};
    endcase
  endfunction

  // MSB-first CRC-32 on bit-reversed input, reflected and inverted at the end.
  function automatic logic [31:0] crc32_tx(input logic [247:0] d, input int n);
    logic [31:0] c, r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ d[8*j+i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  task automatic push_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
  endtask

  function automatic int dec5(input logic [4:0] s);
    for (int n = 0; n < 16; n++) if (enc5(4'(n)) == s) return n;
    return -1;
  endfunction

  function automatic int byte_at(input int pos);
    logic [4:0] lo, hi;
    int l, h;
    if (pos + 10 > dec_q.size()) return -1;
    for (int i = 0; i < 5; i++) begin
      lo[i] = dec_q[pos+i];
      hi[i] = dec_q[pos+5+i];
    end
    l = dec5(lo);
    h = dec5(hi);
    if (l < 0 || h < 0) return -1;
    return h * 16 + l;
  endfunction

  task automatic drive(input vec_t v, input int idx);
    bus.tx_vld  = (idx < v.nbytes) && (idx != v.drop_at);
    bus.tx_dat  = (idx <= 30) ? v.data[8*idx +: 8] : 8'h00;
    bus.tx_last = v.send_last && (idx == v.nbytes - 1);
  endtask

  task automatic run_pkt(input vec_t v, input int t);
    int idx, bad_bits, bad_bmc, bad_tail;
    bit fin;
    logic a, b, prev;
    logic [19:0] os;
    logic [31:0] crc;
    string tg;
    tg = $sformatf("t%0d", t);
    samp.delete();
    exp_q.delete();
    dec_q.delete();
    rdy_n = 0; done_n = 0; err_n = 0; idx = 0; fin = 1'b0;

    @(negedge clk);
    drive(v, idx);
    bus.tx_sop = v.sop;
    bus.tx_go  = 1'b1;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      bus.tx_go = 1'b0;
      if (v.go_again && cyc == 300) begin
        bus.tx_go  = 1'b1;
        bus.tx_sop = 3'd5;
      end
      if (cc_oe) samp.push_back(cc_tx);
      if (bus.tx_done) done_n++;
      if (bus.tx_err) err_n++;
      if (!bus.tx_busy) fin = 1'b1;
      else if (bus.tx_rdy) begin
        rdy_n++;
        @(posedge clk);
        #1;
        idx++;
        drive(v, idx);
      end
    end
    check({tg, " finished"}, 64'(fin), 64'd1);

    // Expected line bits.
    for (int i = 0; i < PRE; i++) exp_q.push_back(1'(i % 2));
    os = os_of(v.sop);
    for (int k = 0; k < 4; k++) push_sym(os[5*k +: 5]);
    for (int j = 0; j < v.exp_rdy; j++) begin
      push_sym(enc5(v.data[8*j +: 4]));
      push_sym(enc5(v.data[8*j+4 +: 4]));
    end
    if (!v.exp_err && v.sop <= 3'd2) begin
      crc = crc32_tx(v.data, v.exp_rdy);
      for (int k = 0; k < 8; k++) push_sym(enc5(crc[4*k +: 4]));
      push_sym(5'b01101);
    end

    check({tg, " oe clocks"}, 64'(samp.size()), 64'(v.exp_bits * 2 * H + H));
    check({tg, " rdy pulses"}, 64'(rdy_n), 64'(v.exp_rdy));
    check({tg, " done pulses"}, 64'(done_n), 64'(v.exp_done));
    check({tg, " err pulses"}, 64'(err_n), 64'(v.exp_err));

    // BMC decode: transition at each bit start, level constant within each half.
    bad_bits = 0; bad_bmc = 0; bad_tail = 0; prev = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if ((k + 1) * 2 * H > samp.size()) begin
        bad_bits++;
        break;
      end
      a = samp[k*2*H];
      b = samp[k*2*H+H];
      for (int j = 0; j < H; j++) begin
        if (samp[k*2*H+j] !== a) bad_bmc++;
        if (samp[k*2*H+H+j] !== b) bad_bmc++;
      end
      if (a === prev) bad_bmc++;
      dec_q.push_back(a ^ b);
      if ((a ^ b) !== exp_q[k]) bad_bits++;
      prev = b;
    end
    for (int j = 0; j < H; j++) begin
      if (exp_q.size() * 2 * H + j >= samp.size()) bad_tail++;
      else if (samp[exp_q.size()*2*H+j] !== 1'b0) bad_tail++;
    end
    check({tg, " bit errors"}, 64'(bad_bits), 64'd0);
    check({tg, " bmc errors"}, 64'(bad_bmc), 64'd0);
    check({tg, " tail low"}, 64'(bad_tail), 64'd0);
    check({tg, " idle line"}, {62'd0, cc_oe, cc_tx}, 64'd0);

    if (t == 0) check({tg, " header"}, 64'(byte_at(94) * 256 + byte_at(84)), 64'h0041);
    if (t == 1) check({tg, " crc bytes"},
                      {32'd0, 8'(byte_at(204)), 8'(byte_at(194)), 8'(byte_at(184)),
                       8'(byte_at(174))}, 64'hCBF43926);
  endtask

  initial begin
    int rcount, idx;
    logic seen;
    bus.tx_go = 1'b0; bus.tx_sop = 3'd0; bus.tx_dat = 8'h00;
    bus.tx_vld = 1'b0; bus.tx_last = 1'b0;

    //          sop   n   drop last again data                           bits rdy done err
    vecs[0] = '{3'd0, 2,  -1, 1'b1, 1'b0, 248'h0041,                     149, 2,  1'b1, 1'b0};
    vecs[1] = '{3'd1, 9,  -1, 1'b1, 1'b0, 248'h393837363534333231,       219, 9,  1'b1, 1'b0};
    vecs[2] = '{3'd5, 0,  -1, 1'b0, 1'b0, 248'h0,                        84,  0,  1'b1, 1'b0};
    vecs[3] = '{3'd6, 0,  -1, 1'b0, 1'b0, 248'h0,                        84,  0,  1'b1, 1'b0};
    vecs[4] = '{3'd2, 3,  -1, 1'b1, 1'b0, 248'h0FFFA5,                   159, 3,  1'b1, 1'b0};
    vecs[5] = '{3'd0, 4,  2,  1'b1, 1'b0, 248'h44332211,                 104, 2,  1'b0, 1'b1};
    vecs[6] = '{3'd1, 31, -1, 1'b0, 1'b1, 248'h0,                        384, 30, 1'b0, 1'b1};
    vecs[7] = '{3'd0, 1,  0,  1'b1, 1'b0, 248'h55,                       84,  0,  1'b0, 1'b1};
    for (int j = 0; j < 31; j++) vecs[6].data[8*j +: 8] = 8'(j * 7 + 3);

    repeat (3) @(negedge clk);
    check("reset outputs", {58'd0, cc_tx, cc_oe, bus.tx_busy, bus.tx_done, bus.tx_err,
                            bus.tx_rdy}, 64'd0);
    rstz = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) run_pkt(vecs[t], t);

    // Illegal ordered-set select must not start a packet.
    @(negedge clk);
    bus.tx_sop = 3'd3;
    bus.tx_go  = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.tx_busy | cc_oe;
    end
    bus.tx_go = 1'b0;
    check("bad sop ignored", 64'(seen), 64'd0);

    // Reset in the middle of the payload, then a clean packet.
    @(negedge clk);
    drive(vecs[4], 0);
    bus.tx_sop = vecs[4].sop;
    bus.tx_go  = 1'b1;
    @(negedge clk);
    bus.tx_go = 1'b0;
    rcount = 0; idx = 0;
    for (int cyc = 0; cyc < 5000 && rcount < 2; cyc++) begin
      @(negedge clk);
      if (bus.tx_rdy) begin
        rcount++;
        @(posedge clk);
        #1;
        idx++;
        drive(vecs[4], idx);
      end
    end
    check("mid data reached", 64'(rcount), 64'd2);
    check("busy before reset", {62'd0, bus.tx_busy, cc_oe}, 64'd3);
    #2 rstz = 1'b0;
    #1;
    check("async reset outs", {61'd0, cc_oe, cc_tx, bus.tx_busy}, 64'd0);
    @(negedge clk);
    rstz = 1'b1;
    bus.tx_vld = 1'b0;
    @(negedge clk);
    run_pkt(vecs[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
